// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bus: pipeline status in, stage-register controls out.
// The master side is the datapath and the slave side is pipeline_ctrl.
interface pipeline_ctrl_if #(
    parameter int unsigned REG_AW   = 3,
    parameter int unsigned MC_CNT_W = 4
);
    logic [REG_AW-1:0]   id_rs1;
    logic [REG_AW-1:0]   id_rs2;
    logic                id_use_rs1;
    logic                id_use_rs2;
    logic [REG_AW-1:0]   ex_rd;
    logic                ex_mem_read;
    logic                branch_taken;
    logic                ex_mc_start;
    logic [MC_CNT_W-1:0] ex_mc_cycles;
    logic                mem_wait;

    logic                pc_en;
    logic                if_id_en;
    logic                id_ex_en;
    logic                ex_mem_en;
    logic                mem_wb_en;
    logic                if_id_flush;
    logic                id_ex_flush;
    logic                ex_mem_flush;
    logic                mem_wb_flush;
    logic                busy;
    logic                proto_err;
    logic [15:0]         stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               branch_taken, ex_mc_start, ex_mc_cycles, mem_wait,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               busy, proto_err, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               branch_taken, ex_mc_start, ex_mc_cycles, mem_wait,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               busy, proto_err, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles,
// taken-branch squashes, multi-cycle EX ops and data-memory wait states.
// Optional stall performance counter enabled by macro PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
    parameter int unsigned REG_AW   = 3,
    parameter int unsigned MC_CNT_W = 4
) (
    input logic             clk,
    input logic             reset_n,
    pipeline_ctrl_if.slave  bus
);
    typedef enum logic {RUN, MULTI} state_t;

    state_t              state, state_n;
    logic [MC_CNT_W-1:0] cnt, cnt_n;
    logic                err_q, err_n;

    logic [REG_AW-1:0]   rs1, rs2, rd;
    logic [MC_CNT_W-1:0] mc_cycles;
    logic                lu, mcs;
    logic                pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;

    assign rs1       = bus.id_rs1;
    assign rs2       = bus.id_rs2;
    assign rd        = bus.ex_rd;
    assign mc_cycles = bus.ex_mc_cycles;

    // Hazard detection from the current stage contents
    always_comb begin
        lu = bus.ex_mem_read && (rd != '0) &&
             ((bus.id_use_rs1 && (rs1 == rd)) || (bus.id_use_rs2 && (rs2 == rd)));
        mcs = (state == MULTI) ||
              (bus.ex_mc_start && (mc_cycles != '0));
    end

    // Prioritised stage-register enables/flushes; everything idle in reset
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (!reset_n) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (bus.mem_wait) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (mcs) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (bus.branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // Next state, countdown and protocol-error detection; all frozen on mem_wait
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n   = err_q;
        if (!bus.mem_wait) begin
            case (state)
                RUN: begin
                    if (bus.ex_mc_start && bus.branch_taken) err_n = 1'b1;
                    // N=0 and N=1 complete within RUN; only longer ops need MULTI
                    if (bus.ex_mc_start && (mc_cycles > MC_CNT_W'(1))) begin
                        cnt_n   = mc_cycles - MC_CNT_W'(1);
                        state_n = MULTI;
                    end
                end
                MULTI: begin
                    if (bus.branch_taken) err_n = 1'b1;
                    cnt_n = cnt - MC_CNT_W'(1);
                    if (cnt == MC_CNT_W'(1)) state_n = RUN;
                end
                default: state_n = RUN;
            endcase
        end
    end

    // FSM, counter and sticky error registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            err_q <= err_n;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] perf_q;

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else if (!pc_en && (perf_q != '1)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign bus.stall_cycles = perf_q;
`else
    assign bus.stall_cycles = '0;
`endif

    assign bus.pc_en        = pc_en;
    assign bus.if_id_en     = if_id_en;
    assign bus.id_ex_en     = id_ex_en;
    assign bus.ex_mem_en    = ex_mem_en;
    assign bus.mem_wb_en    = mem_wb_en;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_flush = ex_mem_flush;
    assign bus.mem_wb_flush = mem_wb_flush;
    assign bus.busy         = reset_n && (state == MULTI);
    assign bus.proto_err    = err_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a cycle-level behavioural model
// tracking "stall cycles remaining" rather than FSM state.
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    pipeline_ctrl_if #(.REG_AW(3), .MC_CNT_W(4)) bus ();

    pipeline_ctrl #(.REG_AW(3), .MC_CNT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pc_stalls_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    int mc_rem = 0;   // stall cycles still owed after the start cycle
    bit m_err  = 0;
    int m_perf = 0;

    // Compare process: evaluate model on the falling edge, inputs are stable
    initial begin
        logic [10:0] exp_v, act_v;
        bit e_pc, e_ifid, e_idex, e_exmem, e_memwb;
        bit f_ifid, f_idex, f_exmem, f_memwb;
        bit lu, mcs;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mc_rem = 0; m_err = 0; m_perf = 0;
            end
            lu  = bus.ex_mem_read && bus.ex_rd != 0 &&
                  ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                   (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
            mcs = (mc_rem > 0) || (bus.ex_mc_start && bus.ex_mc_cycles != 0);
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
            {f_ifid, f_idex, f_exmem, f_memwb} = 4'b0000;
            if (!reset_n) {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b0;
            else if (bus.mem_wait) begin
                {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b0;
                f_memwb = 1;
            end else if (mcs) begin
                e_pc = 0; e_ifid = 0; e_idex = 0; f_exmem = 1;
            end else if (bus.branch_taken) begin
                f_ifid = 1; f_idex = 1;
            end else if (lu) begin
                e_pc = 0; e_ifid = 0; f_idex = 1;
            end
            exp_v = {e_pc, e_ifid, e_idex, e_exmem, e_memwb,
                     f_ifid, f_idex, f_exmem, f_memwb,
                     (reset_n && mc_rem > 0), m_err};
            act_v = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                     bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush,
                     bus.busy, bus.proto_err};
            chk("ctrl_vec", 32'(act_v), 32'(exp_v));
`ifdef PIPE_CTRL_PERF_EN
            chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_perf));
`else
            chk("stall_cycles", 32'(bus.stall_cycles), 32'd0);
`endif
            if (reset_n && !bus.pc_en) pc_stalls_seen++;
            // Advance model to what the next rising edge produces
            if (reset_n) begin
                if (!bus.mem_wait) begin
                    if (bus.branch_taken && (mc_rem > 0 || bus.ex_mc_start)) m_err = 1;
                    if (mc_rem > 0) mc_rem--;
                    else if (bus.ex_mc_start && bus.ex_mc_cycles != 0)
                        mc_rem = int'(bus.ex_mc_cycles) - 1;
                end
                if (!e_pc && m_perf < 65535) m_perf++;
            end
        end
    end

    task automatic idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
        bus.ex_rd = '0; bus.ex_mem_read = 0; bus.branch_taken = 0;
        bus.ex_mc_start = 0; bus.ex_mc_cycles = '0; bus.mem_wait = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic [2:0] rd);
        bus.ex_mem_read = 1; bus.ex_rd = rd; bus.id_rs2 = 3'd3; bus.id_use_rs2 = 1;
    endtask

    task automatic pulse_reset();
        reset_n = 0;
        tick();
        reset_n = 1;
        tick();
    endtask

    // Run one multi-cycle op of length n and return PC-stall cycles observed
    task automatic mc_op(input int n, output int stalls);
        int s0 = pc_stalls_seen;
        idle(); bus.ex_mc_start = 1; bus.ex_mc_cycles = 4'(n);
        tick();
        idle();
        repeat (n + 1) tick();
        stalls = pc_stalls_seen - s0;
    endtask

    initial begin
        int s0, st;
        idle();
        reset_n = 0;
        #2;
        chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        tick(); tick();
        reset_n = 1;
        tick();

        // Multi-cycle N=4 then one load-use bubble: perf total 5
        mc_op(4, st);
        chk("mc4_stall_len", 32'(st), 32'd4);
        s0 = pc_stalls_seen;
        set_lu(3'd3); tick();
        idle(); tick();
        chk("lu_stall_len", 32'(pc_stalls_seen - s0), 32'd1);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_total", 32'(bus.stall_cycles), 32'd5);
`else
        chk("perf_total", 32'(bus.stall_cycles), 32'd0);
`endif

        // Load-use against r0 never stalls
        s0 = pc_stalls_seen;
        set_lu(3'd0); tick();
        idle(); tick();
        chk("lu_r0_stall", 32'(pc_stalls_seen - s0), 32'd0);

        // Branch suppresses load-use
        set_lu(3'd3); bus.branch_taken = 1;
        #1;
        chk("br_flush", 32'({bus.pc_en, bus.if_id_flush, bus.id_ex_flush}), 32'b111);
        tick();
        idle(); tick();

        // N=3 with two wait cycles from stall cycle 2: 5 stalled cycles
        s0 = pc_stalls_seen;
        bus.ex_mc_start = 1; bus.ex_mc_cycles = 4'd3; tick();
        idle(); bus.mem_wait = 1; tick(); tick();
        idle(); repeat (3) tick();
        chk("mw_stall_len", 32'(pc_stalls_seen - s0), 32'd5);

        mc_op(1, st);
        chk("mc1_stall_len", 32'(st), 32'd1);
        mc_op(0, st);
        chk("mc0_stall_len", 32'(st), 32'd0);

        // Illegal start+branch: error latched, MULTI entered
        bus.ex_mc_start = 1; bus.ex_mc_cycles = 4'd2; bus.branch_taken = 1;
        tick();
        idle();
        chk("err_set", 32'(bus.proto_err), 32'd1);
        chk("err_busy", 32'(bus.busy), 32'd1);
        reset_n = 0;
        #1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_err", 32'(bus.proto_err), 32'd0);
        tick();
        reset_n = 1;
        tick();

        // Error is sticky across later cycles
        bus.branch_taken = 1; bus.ex_mc_start = 1; bus.ex_mc_cycles = 4'd0;
        tick();
        idle(); repeat (3) tick();
        chk("err_sticky", 32'(bus.proto_err), 32'd1);
        pulse_reset();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and stall/flush controller for the 5-stage 16-bit pipeline (IF, ID, EX, MEM, WB).
- Drives the enable and flush inputs of the four inter-stage pipeline registers and the PC.
- Handles load-use bubbles, taken-branch squashes, multi-cycle EX operations and data-memory wait states.
- Control outputs are combinational from the current inputs and the registered FSM state, so stage registers respond in the same cycle.

Parameters:
REG_AW, 3, register-address width (8 GPRs; r0 is hardwired zero)
MC_CNT_W, 4, width of the multi-cycle length input and counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_rs1  in  REG_AW  source register 1 of the instruction in ID
id_rs2  in  REG_AW  source register 2 of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_AW  destination register of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
branch_taken  in  1  branch in EX resolved taken
ex_mc_start  in  1  multi-cycle op in EX, first cycle
ex_mc_cycles  in  MC_CNT_W  total stall cycles N required by the op
mem_wait  in  1  data memory not ready for the op in MEM
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage-register enables (0 = hold)
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  stage-register flush (insert bubble)
busy  out  1  FSM in MULTI
proto_err  out  1  sticky illegal-input flag
stall_cycles  out  16  performance counter (see Optional Feature)

Behaviour:
- FSM states: RUN and MULTI. Counter cnt is MC_CNT_W bits wide.
- Reset (reset_n=0, async):
  - state=RUN, cnt=0, proto_err=0, stall_cycles=0.
  - While reset is held, all en=0, all flush=0, busy=0.
- Load-use hazard (LU) = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- MC stall (MCS) = state==MULTI | (state==RUN & ex_mc_start & ex_mc_cycles!=0).
- Output priority, first match wins. Any signal not listed is en=1, flush=0.
  1. mem_wait:
     - all en=0, mem_wb_flush=1.
     - FSM, cnt and error logic frozen (no state change).
  2. MCS:
     - pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1, mem_wb_en=1.
     - branch_taken and LU are ignored.
  3. branch_taken:
     - if_id_flush=1, id_ex_flush=1; pc_en=1 (PC loads the target).
     - LU is ignored.
  4. LU:
     - pc_en=0, if_id_en=0, id_ex_flush=1. Exactly one bubble; LU drops next cycle once the load moves to MEM.
  5. Otherwise: all en=1, flush=0.
- Transitions (only when mem_wait=0):
  - RUN with ex_mc_start=1, N=ex_mc_cycles:
    - N=0: no stall, stay in RUN.
    - N=1: one stall cycle, stay in RUN.
    - N>=2: cnt<=N-1, go to MULTI.
    - The total stall is exactly N cycles, counting the start cycle.
  - MULTI: cnt<=cnt-1; go to RUN when cnt==1 (the last stall cycle). ex_mc_start is ignored in MULTI.
  - mem_wait during MULTI extends the stall by the wait cycles and does not consume cnt.
- proto_err:
  - Set when mem_wait=0 and either (ex_mc_start & branch_taken) in RUN, or (branch_taken in MULTI).
  - Cleared only by reset.
  - For the illegal RUN case, the multi-cycle start takes effect and the branch is dropped.
- Reset asserted mid-MULTI aborts immediately to RUN. No partial stall persists.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cycles increments by 1 on every clk where reset_n=1 and pc_en=0.
  - Saturates at 16'hFFFF.
  - Reset clears it to 0.
- Undefined: stall_cycles is tied to 16'h0000 and no counter flops are inferred.

Test Plan:
- Load-use:
  - Stimulus: ex_mem_read=1, ex_rd=3, id_rs2=3, id_use_rs2=1 for one cycle.
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; next cycle (ex_mem_read=0) all en=1, all flush=0.
  - Repeat with ex_rd=0: no stall.
- Branch:
  - Stimulus: branch_taken=1 together with the load-use inputs above.
  - Response: if_id_flush=1, id_ex_flush=1, pc_en=1; load-use stall suppressed.
- Multi-cycle:
  - Stimulus: ex_mc_start=1, ex_mc_cycles=4.
  - Response: exactly 4 consecutive cycles of pc_en=0 and ex_mc_flush behaviour (ex_mem_flush=1); busy=1 on cycles 2-4; all en=1 on cycle 5.
  - N=1 gives a 1-cycle stall with busy=0; N=0 gives no stall.
- Memory wait inside MULTI:
  - Stimulus: N=3, assert mem_wait for 2 cycles starting at stall cycle 2.
  - Response: total pc_en=0 duration is 5 cycles; mem_wb_flush=1 only during the wait cycles.
- Error and reset:
  - Stimulus: ex_mc_start=1, ex_mc_cycles=2, branch_taken=1.
  - Response: proto_err=1 and stays set; MULTI entered.
  - Then pulse reset_n low mid-MULTI: state=RUN, busy=0, proto_err=0 immediately.
- Perf counter:
  - With PIPE_CTRL_PERF_EN defined, run the multi-cycle (4) and load-use (1) scenarios: stall_cycles=5.
  - Without the macro: stall_cycles=0 throughout.
